// File: rtl/multiplier_sync_if.sv
// Handshake/operand bundle for multiplier_sync.
// master: the block that launches runs and consumes results.
// slave:  the multiplier itself.
interface multiplier_sync_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0] product;
  logic               ready;
  logic               done;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    output addend,
    input  product,
    input  ready,
    input  done
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    input  addend,
    output product,
    output ready,
    output done
  );
endinterface

// File: rtl/multiplier_sync.sv
// multiplier_sync: sequential shift-add multiply-accumulate.
//   product = multiplicand * multiplier + addend (addend zero-extended).
// Single clock (clk), synchronous active-high reset (rst).
// Optional feature macro: MULT_EARLY_TERM_EN
//   undefined -> every run takes WIDTH RUN cycles (data-independent timing,
//                safe for key-dependent operands).
//   defined   -> a run also ends once the remaining multiplier bits are zero.
// Product values are identical in both builds.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready=1, product holds the last result, waiting for a start edge
// RUN   | one shift-add step per clock, count tracks remaining steps
module multiplier_sync #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  multiplier_sync_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q,  mplr_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               ready_q, ready_d;
  logic               done_q,  done_d;

  logic               launch;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplr_shift;
  logic               finish;

  // Rising-edge start detect; only honoured while idle so edges during a run are dropped.
  assign launch = bus.start & ~start_q & (state_q == IDLE);

  // Datapath step values used while running.
  assign acc_sum    = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplr_shift = mplr_q >> 1;

`ifdef MULT_EARLY_TERM_EN
  // Stop as soon as no set multiplier bits remain after this step's shift.
  assign finish = (count_q == CW'(1)) || (mplr_shift == '0);
`else
  assign finish = (count_q == CW'(1));
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    start_d   = bus.start;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    ready_d   = ready_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (launch) begin
          mcand_d = {{WIDTH{1'b0}}, bus.multiplicand};
          mplr_d  = bus.multiplier;
          acc_d   = {{WIDTH{1'b0}}, bus.addend};
          count_d = CW'(WIDTH);
          ready_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_shift;
        count_d = count_q - CW'(1);
        if (finish) begin
          // Result includes this edge's add; partial sums are never exposed.
          product_d = acc_sum;
          ready_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset mid-run discards the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign bus.product = product_q;
  assign bus.ready   = ready_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_multiplier_sync.sv
// Self-checking bench for multiplier_sync against an arithmetic reference
// (A*B + C, and a latency model from the multiplier's MSB position).
module tb_multiplier_sync;

  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  multiplier_sync_if #(.WIDTH(WIDTH)) bus ();

  multiplier_sync #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_product(input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] c);
    longint unsigned p;
    p = longint'(a) * longint'(b) + longint'(c);
    return p;
  endfunction

  // Edges from the launch edge (exclusive) until ready is seen high again.
  function automatic int ref_latency(input logic [15:0] b);
`ifdef MULT_EARLY_TERM_EN
    int msb;
    msb = 0;
    for (int i = 0; i < WIDTH; i++)
      if (b[i]) msb = i;
    return msb + 1;
`else
    return WIDTH;
`endif
  endfunction

  // One complete run; reedge_at >= 0 raises a second start edge at that RUN cycle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input int reedge_at, input bit full);
    int lat;
    int dones;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.addend       = c;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    if (full) check({tag, "_busy"}, bus.ready, 1'b0);
    lat   = 0;
    dones = 0;
    while (!bus.ready && lat < 100) begin
      bus.start = (reedge_at >= 0) && (lat == reedge_at || lat == reedge_at + 1);
      tick();
      lat++;
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    check({tag, "_prod"}, bus.product, ref_product(a, b, c));
    check({tag, "_lat"}, lat, ref_latency(b));
    tick();
    if (bus.done) dones++;
    if (full) begin
      check({tag, "_dones"}, dones, 1);
      check({tag, "_idle"}, bus.ready, 1'b1);
    end
  endtask

  initial begin
    logic [15:0] q, d, r, q2, r2;
    logic [31:0] dividend;
    int dones;
    int low;

    n_cmp = 0;
    n_bad = 0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.addend       = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", bus.ready, 1'b1);
    check("rst_done", bus.done, 1'b0);
    check("rst_prod", bus.product, 0);
    rst = 1'b0;
    tick();

    // T1 / T2 / T3 directed
    run_op("t1", 16'd3, 16'd5, 16'd2, -1, 1'b1);
    check("t1_17", bus.product, 32'd17);
    run_op("t2", 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 1'b1);
    check("t2_max", bus.product, 32'hFFFF_0000);
    run_op("t3", 16'd3, 16'd3, 16'd2, -1, 1'b1);
    check("t3_11", bus.product, 32'd11);
    run_op("zero", 16'd0, 16'd0, 16'h1234, -1, 1'b1);

    // T6 style latency points (expectation follows the build)
    run_op("b1", 16'd9, 16'd1, 16'd0, -1, 1'b1);
    run_op("b8000", 16'd9, 16'h8000, 16'd0, -1, 1'b1);
    run_op("b0", 16'd9, 16'd0, 16'd5, -1, 1'b1);

    // T4: start held high for 40 cycles -> one run only
    bus.multiplicand = 16'd123;
    bus.multiplier   = 16'hC001;
    bus.addend       = 16'd7;
    bus.start        = 1'b1;
    dones = 0;
    low   = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) dones++;
      if (!bus.ready) low++;
    end
    bus.start = 1'b0;
    check("t4_dones", dones, 1);
    check("t4_low", low, ref_latency(16'hC001));
    check("t4_prod", bus.product, ref_product(16'd123, 16'hC001, 16'd7));
    tick();

    // T4: second start edge at RUN cycle 5 ignored
    run_op("t4_reedge", 16'd77, 16'h8421, 16'd3, 4, 1'b1);
    tick();
    check("t4_norelaunch", bus.ready, 1'b1);

    // T5: reset at RUN cycle 7
    bus.multiplicand = 16'd500;
    bus.multiplier   = 16'hFFFF;
    bus.addend       = 16'd1;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    check("t5_ready", bus.ready, 1'b1);
    check("t5_prod", bus.product, 0);
    check("t5_done", bus.done, 1'b0);
    rst = 1'b0;
    tick();
    run_op("t5_after", 16'd7, 16'd6, 16'd0, -1, 1'b1);
    check("t5_42", bus.product, 32'd42);

    // Random multiply-accumulate
    for (int i = 0; i < 100; i++)
      run_op("rand_mac", 16'($urandom), 16'($urandom), 16'($urandom), -1, 1'b1);

    // T3: divider round trip, product must rebuild the dividend
    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom_range(1, 65535));
      q = 16'($urandom);
      r = 16'($urandom_range(0, int'(d) - 1));
      dividend = 32'(q) * 32'(d) + 32'(r);
      q2 = 16'(dividend / 32'(d));
      r2 = 16'(dividend % 32'(d));
      run_op("rt", q2, d, r2, -1, 1'b0);
      check("rt_dividend", bus.product, dividend);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
